systolic_feeder: RTL and testbench
==================================

SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 Param ROWS, default 2, number of PE rows driven (1..8).
REQ-002 Param COLS, default 2, number of PE columns (weight-row width, 1..8).
REQ-003 Param DATA_WIDTH, default 16, signed fixed-point word width.
REQ-004 clk  in  1  single clock; all logic on posedge clk.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  begin a batch; sampled only in IDLE.
REQ-007 num_vec  in  8  input vectors in the batch, latched on accepted start.
REQ-008 w_valid_in / w_ready_out / w_data_in  in / out / COLS*DATA_WIDTH  weight-row beat handshake; lane c = column c.
REQ-009 x_valid_in / x_ready_out / x_data_in  in / out / ROWS*DATA_WIDTH  input-vector beat handshake; lane r = row r.
REQ-010 load_weight_out  out  ROWS  one-hot per-row weight-load strobe to the array.
REQ-011 weight_out  out  COLS*DATA_WIDTH  weight row broadcast to all rows.
REQ-012 input_out  out  ROWS*DATA_WIDTH  skewed activations, lane r to row r, column 0.
REQ-013 pe_valid_out  out  ROWS  skewed valid, bit r to row r, column 0.
REQ-014 busy  out  1  high in any state other than IDLE.
REQ-015 done  out  1  single-cycle pulse at batch completion.

Function
REQ-016 FSM states SHALL be IDLE, LOAD_W, STREAM, DRAIN.
REQ-017 IDLE: start=1 SHALL latch num_vec, clear row counter, move to LOAD_W next cycle; start in other states SHALL be ignored.
REQ-018 A beat transfers only when valid and ready are both high in the same cycle.
REQ-019 w_ready_out SHALL be 1 only in LOAD_W; x_ready_out SHALL be 1 only in STREAM; both 0 otherwise.
REQ-020 LOAD_W: weight beat k (k=0..ROWS-1) accepted at cycle t SHALL drive load_weight_out=1<<k and weight_out=w_data_in at t+1, else load_weight_out=0.
REQ-021 After beat ROWS-1 is accepted, FSM SHALL go to STREAM, or to DRAIN if latched num_vec==0.
REQ-022 STREAM: vector accepted at cycle t SHALL present lane r on input_out lane r with pe_valid_out[r]=1 at cycle t+1+r.
REQ-023 Cycles with no accepted vector SHALL propagate as bubbles: pe_valid_out[r]=0 and input_out lane r=0, r cycles later, preserving skew alignment.
REQ-024 After num_vec vectors are accepted, FSM SHALL go to DRAIN; excess x beats SHALL NOT be accepted.
REQ-025 DRAIN SHALL last exactly ROWS cycles (flushing skew), then pulse done=1 for one cycle coinciding with the return to IDLE.
REQ-026 Feeder SHALL never assert load_weight_out and any pe_valid_out bit in the same cycle.
REQ-027 Data SHALL pass unmodified (no arithmetic, no saturation); vector counter SHALL be 8 bits, num_vec=255 SHALL feed 255 vectors.

Reset
REQ-028 rst=1 SHALL force IDLE, clear counters and all skew stages, and drive every output to 0 on the next edge, including mid-batch.
REQ-029 In-flight skewed data SHALL be discarded on reset; no valid SHALL emerge after reset deasserts until a new batch.

Structure
REQ-030 Shared package tpu_pkg SHALL hold DATA_WIDTH default and the feeder state enum type.
REQ-031 Per-row delay SHALL be a sub-module skew_delay (param DEPTH, carries data+valid, DEPTH=0 is passthrough register-only), instantiated ROWS times with DEPTH=r.

Verification
REQ-032 Reset mid-STREAM (ROWS=2, 3 of 5 vectors sent) -> next cycle all outputs 0, busy=0; no later pe_valid_out.
REQ-033 Weight load ROWS=2, COLS=2: beats {0x0100,0x0200},{0x0300,0x0400} back-to-back -> load_weight_out 01 then 10 with matching weight_out, then STREAM.
REQ-034 Stream 3 vectors {0x0100,0x0200},{0x0300,0x0400},{0x0500,0x0600} continuously -> row0 0x0100/0x0300/0x0500 at t+1..t+3, row1 0x0200/0x0400/0x0600 at t+2..t+4; done 2 cycles after DRAIN entry.
REQ-035 x_valid_in low one cycle between vectors 1 and 2 -> bubble appears on row0 then row1 one cycle later; values unchanged.
REQ-036 num_vec=0 -> weights load, no pe_valid_out ever, done after ROWS DRAIN cycles; start during busy ignored.
REQ-037 x_valid_in held high after last vector -> x_ready_out=0, no extra beat consumed.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared types and defaults for the systolic array front end.
package tpu_pkg;

    localparam int DATA_WIDTH_DEFAULT = 16;
    localparam int CNT_W              = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_W = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } feeder_state_e;

endpackage

// File: rtl/systolic_feeder_if.sv
// Batch control, weight/activation beat handshakes and array-facing outputs of the feeder.
interface systolic_feeder_if #(
    parameter int ROWS       = 2,
    parameter int COLS       = 2,
    parameter int DATA_WIDTH = tpu_pkg::DATA_WIDTH_DEFAULT
);
    logic                       start;
    logic [7:0]                 num_vec;
    logic                       w_valid_in;
    logic                       w_ready_out;
    logic [COLS*DATA_WIDTH-1:0] w_data_in;
    logic                       x_valid_in;
    logic                       x_ready_out;
    logic [ROWS*DATA_WIDTH-1:0] x_data_in;
    logic [ROWS-1:0]            load_weight_out;
    logic [COLS*DATA_WIDTH-1:0] weight_out;
    logic [ROWS*DATA_WIDTH-1:0] input_out;
    logic [ROWS-1:0]            pe_valid_out;
    logic                       busy;
    logic                       done;

    modport slave (
        input  start, num_vec, w_valid_in, w_data_in, x_valid_in, x_data_in,
        output w_ready_out, x_ready_out, load_weight_out, weight_out,
               input_out, pe_valid_out, busy, done
    );

    modport master (
        output start, num_vec, w_valid_in, w_data_in, x_valid_in, x_data_in,
        input  w_ready_out, x_ready_out, load_weight_out, weight_out,
               input_out, pe_valid_out, busy, done
    );
endinterface

// File: rtl/systolic_feeder_skew_delay.sv
// Per-row skew line: one input register plus DEPTH further stages of data+valid.
// Latency 1+DEPTH cycles; no backpressure, every cycle advances.
module skew_delay #(
    parameter int DEPTH = 0,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vld_i,
    input  logic [WIDTH-1:0] dat_i,
    output logic             vld_o,
    output logic [WIDTH-1:0] dat_o
);
    logic             vld_q [DEPTH+1];
    logic [WIDTH-1:0] dat_q [DEPTH+1];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= DEPTH; i++) begin
                vld_q[i] <= 1'b0;
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= vld_i;
            dat_q[0] <= dat_i;
            for (int i = 1; i <= DEPTH; i++) begin
                vld_q[i] <= vld_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
        end
    end

    assign vld_o = vld_q[DEPTH];
    assign dat_o = dat_q[DEPTH];
endmodule

// File: rtl/systolic_feeder.sv
// Loads one weight row per PE row, then streams skewed activation vectors into column 0.
// Weight strobe 1 cycle after accept; row r activation 1+r cycles after accept; ready only in its phase.
module systolic_feeder
    import tpu_pkg::*;
#(
    parameter int ROWS       = 2,
    parameter int COLS       = 2,
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    systolic_feeder_if.slave  bus
);
    localparam int                RW      = 3;
    localparam logic [ROWS-1:0]   ROW_ONE = ROWS'(1);

    feeder_state_e              state_q, state_d;
    logic [RW-1:0]              row_cnt_q, row_cnt_d;
    logic [RW-1:0]              drain_cnt_q, drain_cnt_d;
    logic [CNT_W-1:0]           vec_cnt_q, vec_cnt_d;
    logic [CNT_W-1:0]           num_vec_q, num_vec_d;
    logic [ROWS-1:0]            load_weight_q, load_weight_d;
    logic [COLS*DATA_WIDTH-1:0] weight_q, weight_d;
    logic                       done_q, done_d;

    logic w_rdy, x_rdy, w_fire, x_fire;
    logic last_row, last_vec, last_drain;

    assign w_fire     = bus.w_valid_in && w_rdy;
    assign x_fire     = bus.x_valid_in && x_rdy;
    assign last_row   = (row_cnt_q == RW'(ROWS - 1));
    assign last_vec   = ((vec_cnt_q + CNT_W'(1)) == num_vec_q);
    assign last_drain = (drain_cnt_q == RW'(ROWS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = LOAD_W;
            LOAD_W:  if (w_fire && last_row) state_d = (num_vec_q == '0) ? DRAIN : STREAM;
            STREAM:  if (x_fire && last_vec) state_d = DRAIN;
            DRAIN:   if (last_drain) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        w_rdy = (state_q == LOAD_W);
        x_rdy = (state_q == STREAM);
    end

    always_comb begin
        row_cnt_d   = row_cnt_q;
        vec_cnt_d   = vec_cnt_q;
        drain_cnt_d = drain_cnt_q;
        num_vec_d   = num_vec_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    num_vec_d   = bus.num_vec;
                    row_cnt_d   = '0;
                    vec_cnt_d   = '0;
                    drain_cnt_d = '0;
                end
            end
            LOAD_W:  if (w_fire) row_cnt_d = row_cnt_q + RW'(1);
            STREAM:  if (x_fire) vec_cnt_d = vec_cnt_q + CNT_W'(1);
            DRAIN:   drain_cnt_d = drain_cnt_q + RW'(1);
            default: ;
        endcase
        load_weight_d = w_fire ? (ROW_ONE << row_cnt_q) : '0;
        weight_d      = w_fire ? bus.w_data_in : weight_q;
        done_d        = (state_q == DRAIN) && last_drain;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_cnt_q     <= '0;
            vec_cnt_q     <= '0;
            drain_cnt_q   <= '0;
            num_vec_q     <= '0;
            load_weight_q <= '0;
            weight_q      <= '0;
            done_q        <= 1'b0;
        end else begin
            row_cnt_q     <= row_cnt_d;
            vec_cnt_q     <= vec_cnt_d;
            drain_cnt_q   <= drain_cnt_d;
            num_vec_q     <= num_vec_d;
            load_weight_q <= load_weight_d;
            weight_q      <= weight_d;
            done_q        <= done_d;
        end
    end

    // Idle cycles inject zero data with valid low so bubbles keep the diagonal aligned.
    logic [ROWS-1:0]                 lane_vld;
    logic [ROWS-1:0][DATA_WIDTH-1:0] lane_dat;

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        logic [DATA_WIDTH-1:0] x_lane;
        assign x_lane = x_fire ? bus.x_data_in[r*DATA_WIDTH +: DATA_WIDTH] : '0;

        skew_delay #(
            .DEPTH (r),
            .WIDTH (DATA_WIDTH)
        ) u_skew (
            .clk   (clk),
            .rst   (rst),
            .vld_i (x_fire),
            .dat_i (x_lane),
            .vld_o (lane_vld[r]),
            .dat_o (lane_dat[r])
        );
    end

    assign bus.w_ready_out     = w_rdy;
    assign bus.x_ready_out     = x_rdy;
    assign bus.busy            = (state_q != IDLE);
    assign bus.done            = done_q;
    assign bus.load_weight_out = load_weight_q;
    assign bus.weight_out      = weight_q;
    assign bus.pe_valid_out    = lane_vld;
    assign bus.input_out       = lane_dat;
endmodule

// File: tb/tb_systolic_feeder.sv
// Directed and randomized batches checked cycle-by-cycle against an event-time reference model.
module tb_systolic_feeder;
    localparam int ROWS = 2;
    localparam int COLS = 2;
    localparam int DW   = 16;
    localparam int NC   = 8192;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    systolic_feeder_if #(.ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW)) bus();

    systolic_feeder #(.ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Expected array-facing outputs, indexed by absolute cycle number.
    logic [ROWS-1:0]    exp_lw   [NC];
    logic [COLS*DW-1:0] exp_wt   [NC];
    logic [ROWS-1:0]    exp_pv   [NC];
    logic [ROWS*DW-1:0] exp_in   [NC];
    logic               exp_done [NC];

    // Batch bookkeeping: when it started and how many beats of each kind were taken.
    bit m_active;
    int m_st, m_nv, m_wacc, m_xacc, m_done_cyc;

    logic [COLS*DW-1:0] dir_w [ROWS];
    logic [ROWS*DW-1:0] dir_x [3];

    function automatic bit load_win();
        return m_active && (cyc > m_st) && (m_wacc < ROWS);
    endfunction

    function automatic bit strm_win();
        return m_active && (m_wacc == ROWS) && (m_xacc < m_nv);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_assert++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, want);
        end
    endtask

    task automatic check_outputs();
        chk("w_ready_out", bus.w_ready_out, load_win());
        chk("x_ready_out", bus.x_ready_out, strm_win());
        chk("busy", bus.busy, m_active && (cyc > m_st));
        chk("done", bus.done, exp_done[cyc]);
        chk("load_weight_out", bus.load_weight_out, exp_lw[cyc]);
        if (exp_lw[cyc] != '0) chk("weight_out", bus.weight_out, exp_wt[cyc]);
        chk("pe_valid_out", bus.pe_valid_out, exp_pv[cyc]);
        chk("input_out", bus.input_out, exp_in[cyc]);
        chk("load_vs_valid_exclusive", (|bus.load_weight_out) && (|bus.pe_valid_out), 1'b0);
    endtask

    task automatic finish_batch_at(input int k);
        m_done_cyc = k + 1 + ROWS;
        exp_done[m_done_cyc] = 1'b1;
    endtask

    task automatic model_edge();
        bit lw, sw;
        lw = load_win();
        sw = strm_win();
        if (rst) begin
            m_active   = 1'b0;
            m_done_cyc = -1;
            for (int c = cyc + 1; c <= cyc + ROWS + 2; c++) begin
                exp_lw[c] = '0; exp_pv[c] = '0; exp_in[c] = '0; exp_done[c] = 1'b0;
            end
        end else if (!m_active) begin
            if (bus.start) begin
                m_active   = 1'b1;
                m_st       = cyc;
                m_nv       = int'(bus.num_vec);
                m_wacc     = 0;
                m_xacc     = 0;
                m_done_cyc = -1;
            end
        end else if (lw && bus.w_valid_in) begin
            exp_lw[cyc+1] = ROWS'(1) << m_wacc;
            exp_wt[cyc+1] = bus.w_data_in;
            m_wacc++;
            if (m_wacc == ROWS && m_nv == 0) finish_batch_at(cyc);
        end else if (sw && bus.x_valid_in) begin
            for (int r = 0; r < ROWS; r++) begin
                exp_pv[cyc+1+r][r]         = 1'b1;
                exp_in[cyc+1+r][r*DW +: DW] = bus.x_data_in[r*DW +: DW];
            end
            m_xacc++;
            if (m_xacc == m_nv) finish_batch_at(cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        if (m_active && m_done_cyc >= 0 && cyc >= m_done_cyc) m_active = 1'b0;
    endtask

    task automatic run_batch(input int nv, input int w_prob, input int x_prob,
                             input bit use_dir, input int gap_at, input int rst_at);
        int iter;
        bit gap_done;
        iter     = 0;
        gap_done = 1'b0;
        do begin
            if (iter == 0) begin
                bus.start   = 1'b1;
                bus.num_vec = 8'(nv);
            end else begin
                bus.start   = ($urandom_range(0, 3) == 0);
                bus.num_vec = 8'($urandom);
            end
            bus.w_valid_in = ($urandom_range(0, 99) < w_prob);
            bus.w_data_in  = (use_dir && m_wacc < ROWS) ? dir_w[m_wacc] : (COLS*DW)'($urandom);
            if (gap_at >= 0 && !gap_done && m_xacc == gap_at && strm_win()) begin
                bus.x_valid_in = 1'b0;
                gap_done       = 1'b1;
            end else begin
                bus.x_valid_in = ($urandom_range(0, 99) < x_prob);
            end
            bus.x_data_in = (use_dir && m_xacc < 3) ? dir_x[m_xacc] : (ROWS*DW)'($urandom);
            rst = (rst_at >= 0 && m_xacc == rst_at && strm_win());
            tick();
            iter++;
        end while (m_active && iter < 3000);
        rst       = 1'b0;
        bus.start = 1'b0;
        repeat (ROWS + 3) begin
            bus.w_valid_in = $urandom_range(0, 1) == 1;
            bus.x_valid_in = (x_prob == 100) ? 1'b1 : ($urandom_range(0, 1) == 1);
            tick();
        end
        chk("batch_timeout", iter >= 3000, 1'b0);
    endtask

    initial begin
        for (int c = 0; c < NC; c++) begin
            exp_lw[c] = '0; exp_wt[c] = '0; exp_pv[c] = '0; exp_in[c] = '0; exp_done[c] = 1'b0;
        end
        m_active   = 1'b0;
        m_st       = 0;
        m_nv       = 0;
        m_wacc     = 0;
        m_xacc     = 0;
        m_done_cyc = -1;

        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.num_vec    = '0;
        bus.w_valid_in = 1'b0;
        bus.w_data_in  = '0;
        bus.x_valid_in = 1'b0;
        bus.x_data_in  = '0;
        @(posedge clk);
        cyc = 1;
        #1;
        tick();
        tick();
        rst = 1'b0;
        repeat (3) tick();

        dir_w[0] = 32'h0200_0100;
        dir_w[1] = 32'h0400_0300;
        dir_x[0] = 32'h0200_0100;
        dir_x[1] = 32'h0400_0300;
        dir_x[2] = 32'h0600_0500;

        // Back-to-back weights, continuous vectors, x_valid left high afterwards.
        run_batch(3, 100, 100, 1'b1, -1, -1);
        // One-cycle hole between the first and second vector.
        run_batch(3, 100, 100, 1'b1, 1, -1);
        // Empty batch: weights only, straight to drain.
        run_batch(0, 100, 100, 1'b0, -1, -1);
        // Reset after 3 of 5 vectors, with data still in the skew lines.
        run_batch(5, 100, 100, 1'b0, -1, 3);

        for (int b = 0; b < 10; b++) begin
            run_batch($urandom_range(0, 12), $urandom_range(40, 100), $urandom_range(40, 100),
                      1'b0, -1, -1);
        end

        run_batch(255, 100, 100, 1'b0, -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
